p08_muldiv_seq: RTL and testbench

P08_MULDIV_SEQ -- requirements
Module: p08_muldiv_seq

---
 rtl/p08_muldiv_seq.sv | 215 +++++++++++++++++++++
 tb/tb_p08_muldiv_seq.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/p08_muldiv_seq.sv
// ---------------------------------------------------------------------------
// p08_muldiv_seq
// Sequential 4x4 unsigned multiplier with an optional 4/4 restoring divider.
// Every operation takes one accept cycle, four iteration cycles and one
// DONE cycle. A divide by zero finishes right after the first RUN edge.
//
// Configuration macro: P08_MULDIV_DIVIDE_EN
//   defined   -> op selects multiply (0) or divide (1), and dbz is live.
//   undefined -> the divider is not built, op is ignored, every operation
//                multiplies, and dbz is tied to 0.
//
// Ports
//   clk     in   1  clock; all state changes on the rising edge
//   reset   in   1  synchronous, active-high reset
//   start   in   1  request pulse, only looked at in IDLE
//   op      in   1  0 = multiply, 1 = divide (divide build only)
//   a       in   4  multiplicand / dividend
//   b       in   4  multiplier / divisor
//   busy    out  1  high in RUN
//   done    out  1  single-cycle strobe in DONE
//   result  out  8  product, or {remainder, quotient}; 0 during RUN
//   dbz     out  1  divide-by-zero flag for the last operation
// ---------------------------------------------------------------------------
module p08_muldiv_seq (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       op,
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic       busy,
    output logic       done,
    output logic [7:0] result,
    output logic       dbz
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t     state_reg, state_next;
    logic [1:0] cnt_reg, cnt_next;
    // opnd_reg: multiplicand (multiply) or divisor (divide)
    logic [3:0] opnd_reg, opnd_next;
    // acc_reg: upper product nibble (multiply) or partial remainder (divide)
    logic [3:0] acc_reg, acc_next;
    // mq_reg: multiplier being shifted out, or dividend shifting into quotient
    logic [3:0] mq_reg, mq_next;
    logic [7:0] result_reg, result_next;

    // ------------------------------------------------------------------
    // Multiply iteration: conditional add into the upper nibble, then a
    // right shift of {carry, acc, mq}.
    // ------------------------------------------------------------------
    logic [4:0] mul_sum;
    logic [3:0] mul_acc;
    logic [3:0] mul_mq;

    assign mul_sum   = {1'b0, acc_reg} + (mq_reg[0] ? {1'b0, opnd_reg} : 5'd0);
    assign mul_acc   = mul_sum[4:1];
    assign mul_mq[3] = mul_sum[0];

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_mul_shift
            assign mul_mq[gi] = mq_reg[gi+1];
        end
    endgenerate

    logic [3:0] step_acc;
    logic [3:0] step_mq;
    logic       is_dbz;

`ifdef P08_MULDIV_DIVIDE_EN
    logic op_reg, op_next;
    logic dbz_reg, dbz_next;

    // ------------------------------------------------------------------
    // Restoring divide iteration. The partial remainder is always below
    // the divisor, so {rem, next dividend bit} fits in 5 bits; one extra
    // bit on the trial difference gives the borrow.
    // ------------------------------------------------------------------
    logic [4:0] div_part;
    logic [5:0] div_trial;
    logic       div_fit;
    logic [3:0] div_acc;
    logic [3:0] div_mq;
    logic       unused_div_msb;

    assign div_part       = {acc_reg, mq_reg[3]};
    assign div_trial      = {1'b0, div_part} - {2'b00, opnd_reg};
    assign div_fit        = ~div_trial[5];
    // On a successful trial the difference is below the divisor, so bit 4 is 0.
    assign unused_div_msb = div_trial[4];
    assign div_acc        = div_fit ? div_trial[3:0] : div_part[3:0];
    assign div_mq[0]      = div_fit;

    generate
        for (genvar gi = 1; gi < 4; gi++) begin : g_div_shift
            assign div_mq[gi] = mq_reg[gi-1];
        end
    endgenerate

    assign step_acc = op_reg ? div_acc : mul_acc;
    assign step_mq  = op_reg ? div_mq  : mul_mq;
    assign is_dbz   = op_reg && (opnd_reg == 4'd0);
    assign dbz      = dbz_reg;
`else
    logic unused_op;

    assign unused_op = op;
    assign step_acc  = mul_acc;
    assign step_mq   = mul_mq;
    assign is_dbz    = 1'b0;
    assign dbz       = 1'b0;
`endif

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= ST_IDLE;
            cnt_reg    <= 2'd0;
            opnd_reg   <= 4'd0;
            acc_reg    <= 4'd0;
            mq_reg     <= 4'd0;
            result_reg <= 8'd0;
`ifdef P08_MULDIV_DIVIDE_EN
            op_reg     <= 1'b0;
            dbz_reg    <= 1'b0;
`endif
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            opnd_reg   <= opnd_next;
            acc_reg    <= acc_next;
            mq_reg     <= mq_next;
            result_reg <= result_next;
`ifdef P08_MULDIV_DIVIDE_EN
            op_reg     <= op_next;
            dbz_reg    <= dbz_next;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Next-state and datapath control
    // ------------------------------------------------------------------
    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        opnd_next   = opnd_reg;
        acc_next    = acc_reg;
        mq_next     = mq_reg;
        result_next = result_reg;
`ifdef P08_MULDIV_DIVIDE_EN
        op_next     = op_reg;
        dbz_next    = dbz_reg;
`endif

        case (state_reg)
            ST_IDLE: begin
                if (start) begin
`ifdef P08_MULDIV_DIVIDE_EN
                    op_next   = op;
                    opnd_next = op ? b : a;
                    mq_next   = op ? a : b;
                    dbz_next  = 1'b0;
`else
                    opnd_next = a;
                    mq_next   = b;
`endif
                    acc_next    = 4'd0;
                    cnt_next    = 2'd0;
                    result_next = 8'd0;
                    state_next  = ST_RUN;
                end
            end

            ST_RUN: begin
                if (is_dbz) begin
                    // mq_reg still holds the untouched dividend here.
                    result_next = {mq_reg, 4'hF};
`ifdef P08_MULDIV_DIVIDE_EN
                    dbz_next    = 1'b1;
`endif
                    state_next  = ST_DONE;
                end else begin
                    acc_next = step_acc;
                    mq_next  = step_mq;
                    cnt_next = cnt_reg + 2'd1;
                    if (cnt_reg == 2'd3) begin
                        result_next = {step_acc, step_mq};
                        state_next  = ST_DONE;
                    end
                end
            end

            ST_DONE: begin
                state_next = ST_IDLE;
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign busy   = (state_reg == ST_RUN);
    assign done   = (state_reg == ST_DONE);
    assign result = result_reg;

endmodule

// File: tb/tb_p08_muldiv_seq.sv
// ---------------------------------------------------------------------------
// tb_p08_muldiv_seq
// Self-checking bench for p08_muldiv_seq: a directed vector table, hand
// sequences for reset-in-RUN and ignored/held start, then random operations
// checked against an arithmetic reference model. Adapts to whether
// P08_MULDIV_DIVIDE_EN is defined.
// ---------------------------------------------------------------------------
module tb_p08_muldiv_seq;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       op;
    logic [3:0] a;
    logic [3:0] b;
    logic       busy;
    logic       done;
    logic [7:0] result;
    logic       dbz;

    int n_vec = 0;
    int n_err = 0;

    p08_muldiv_seq dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result),
        .dbz    (dbz)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       o;
        logic [3:0] x;
        logic [3:0] y;
        logic [7:0] r;
        logic       z;
        int         lat;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference: plain arithmetic on the operands.
    function automatic void model(input logic o, input logic [3:0] x, input logic [3:0] y,
                                  output logic [7:0] r, output logic z, output int lat);
        int q;
        int m;
        r   = 8'(int'(x) * int'(y));
        z   = 1'b0;
        lat = 4;
`ifdef P08_MULDIV_DIVIDE_EN
        if (o) begin
            if (y == 4'd0) begin
                r   = {x, 4'hF};
                z   = 1'b1;
                lat = 1;
            end else begin
                q = int'(x) / int'(y);
                m = int'(x) % int'(y);
                r = {m[3:0], q[3:0]};
            end
        end
`endif
    endfunction

    // Wait for done, counting edges; bounded so a stuck DUT still ends.
    task automatic wait_done(output int k);
        k = 0;
        while (done !== 1'b1 && k < 12) begin
            @(negedge clk);
            k++;
        end
    endtask

    // Called at a negedge with the DUT in IDLE; returns at a negedge in IDLE.
    task automatic run_op(input logic o, input logic [3:0] x, input logic [3:0] y,
                          input logic [7:0] er, input logic ez, input int elat);
        int k;
        start = 1'b1; op = o; a = x; b = y;
        @(negedge clk);
        start = 1'b0;
        op = 1'($urandom); a = 4'($urandom); b = 4'($urandom);
        check("busy_after_accept", busy, 1'b1);
        check("result_zero_in_run", result, 8'h00);
        wait_done(k);
        check("latency", k, elat);
        check("busy_in_done", busy, 1'b0);
        check("result", result, er);
        check("dbz", dbz, ez);
        @(negedge clk);
        check("done_one_cycle", done, 1'b0);
        check("result_held", result, er);
        $display("txn op=%0d a=%0d b=%0d result=%02h dbz=%0d latency=%0d", o, x, y, result, dbz, k);
    endtask

    vec_t tbl[7];

    initial begin
        int         k;
        int         seen;
        logic       ro;
        logic [3:0] rx;
        logic [3:0] ry;
        logic [7:0] rr;
        logic       rz;
        int         rl;

`ifdef P08_MULDIV_DIVIDE_EN
        tbl[0] = '{1'b0, 4'd13, 4'd11, 8'h8F, 1'b0, 4};
        tbl[1] = '{1'b1, 4'd14, 4'd3,  8'h24, 1'b0, 4};
        tbl[2] = '{1'b1, 4'd15, 4'd15, 8'h01, 1'b0, 4};
        tbl[3] = '{1'b1, 4'd9,  4'd0,  8'h9F, 1'b1, 1};
        tbl[4] = '{1'b0, 4'd2,  4'd3,  8'h06, 1'b0, 4};
        tbl[5] = '{1'b1, 4'd7,  4'd1,  8'h07, 1'b0, 4};
        tbl[6] = '{1'b0, 4'd15, 4'd15, 8'hE1, 1'b0, 4};
`else
        tbl[0] = '{1'b0, 4'd13, 4'd11, 8'h8F, 1'b0, 4};
        tbl[1] = '{1'b1, 4'd4,  4'd5,  8'h14, 1'b0, 4};
        tbl[2] = '{1'b1, 4'd14, 4'd3,  8'h2A, 1'b0, 4};
        tbl[3] = '{1'b1, 4'd9,  4'd0,  8'h00, 1'b0, 4};
        tbl[4] = '{1'b0, 4'd2,  4'd3,  8'h06, 1'b0, 4};
        tbl[5] = '{1'b1, 4'd7,  4'd1,  8'h07, 1'b0, 4};
        tbl[6] = '{1'b0, 4'd15, 4'd15, 8'hE1, 1'b0, 4};
`endif

        reset = 1'b1; start = 1'b1; op = 1'b0; a = 4'd5; b = 4'd5;
        repeat (2) @(negedge clk);
        check("reset_busy", busy, 1'b0);
        check("reset_done", done, 1'b0);
        check("reset_result", result, 8'h00);
        check("reset_dbz", dbz, 1'b0);
        reset = 1'b0;
        start = 1'b0;

        // Directed table; consecutive calls are back-to-back.
        for (int i = 0; i < 7; i++)
            run_op(tbl[i].o, tbl[i].x, tbl[i].y, tbl[i].r, tbl[i].z, tbl[i].lat);

        // Reset sampled at edge N+2 aborts the operation.
        start = 1'b1; op = 1'b0; a = 4'd15; b = 4'd15;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_busy", busy, 1'b0);
        check("abort_done", done, 1'b0);
        check("abort_result", result, 8'h00);
        check("abort_dbz", dbz, 1'b0);
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (done === 1'b1) seen++;
        end
        check("no_done_after_abort", seen, 0);
        $display("txn reset mid-run, done pulses seen=%0d", seen);
        run_op(1'b0, 4'd15, 4'd15, 8'hE1, 1'b0, 4);

        // Start held high through RUN/DONE with new operands: ignored until IDLE.
        start = 1'b1; op = 1'b0; a = 4'd13; b = 4'd11;
        @(negedge clk);
        a = 4'd2; b = 4'd2;
        wait_done(k);
        check("held_first_latency", k, 4);
        check("held_first_result", result, 8'h8F);
        @(negedge clk);
        check("held_idle_busy", busy, 1'b0);
        check("held_idle_result", result, 8'h8F);
        @(negedge clk);
        start = 1'b0;
        check("held_accepted", busy, 1'b1);
        wait_done(k);
        check("held_second_latency", k, 4);
        check("held_second_result", result, 8'h04);
        $display("txn held start: second result=%02h latency=%0d", result, k);
        @(negedge clk);

        // Random operations against the arithmetic model.
        for (int i = 0; i < 40; i++) begin
            ro = 1'($urandom);
            rx = 4'($urandom);
            ry = ($urandom_range(0, 5) == 0) ? 4'd0 : 4'($urandom);
            model(ro, rx, ry, rr, rz, rl);
            run_op(ro, rx, ry, rr, rz, rl);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
